load_store_buffer: RTL and testbench
====================================

// Module: load_store_buffer
// PURPOSE
// - In-order load/store queue directly upstream of the Cache data port. Accepts
//   address-resolved memory ops from dispatch, issues them one at a time on the
//   accessType/readWrite/addr/data request, waits for dataOutValid/dataWriteSuc,
//   extends load data, broadcasts results with ROB index. Stores issue only after
//   ROB commit; IO loads (addr[17:16]==2'b11) issue only at ROB head.
// PARAMETERS
// - LSB_WIDTH  4             log2 of queue depth
// - LSB_SIZE   2**LSB_WIDTH  queue entries
// - ROB_WIDTH  4             ROB index width
// PORTS
// - clkIn          in   1          system clock
// - resetIn        in   1          synchronous reset, active-high
// - clearIn        in   1          mispredict flush
// - entryInValid   in   1          enqueue strobe
// - entryIsLoad    in   1          1: load, 0: store
// - entryFunct3    in   3          LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
// - entryAddr      in   32         effective address
// - entryData      in   32         store data (ignored for loads)
// - entryRobIndex  in   ROB_WIDTH  destination/ROB tag
// - commitStoreIn  in   1          pulse: oldest uncommitted store committed
// - robHeadIndex   in   ROB_WIDTH  ROB index currently at head
// - full           out  1          count==LSB_SIZE
// - accessType     out  2          to Cache: 00 none, 01 B, 10 H, 11 W
// - readWriteOut   out  1          to Cache: 1 read, 0 write
// - dataAddrOut    out  32         to Cache: address
// - dataOut        out  32         to Cache: store data, low bits significant
// - dataInValid    in   1          from Cache: load data valid
// - dataIn         in   32         from Cache: load data, zero-extended in low bits
// - dataWriteSuc   in   1          from Cache: store done
// - resultValid    out  1          load result broadcast, 1-cycle pulse
// - resultData     out  32         extended load value
// - resultRobIndex out  ROB_WIDTH  tag of result
// BEHAVIOUR
// - Reset: queue empty, head=tail=count=committedCount=0, state IDLE;
//   accessType=00, readWriteOut=1, dataAddrOut=0, dataOut=0, resultValid=0,
//   resultData=0, resultRobIndex=0, full=0.
// - Circular buffer; head/tail LSB_WIDTH bits, wrap modulo LSB_SIZE; count
//   LSB_WIDTH+1 bits. Enqueue when entryInValid && !full; ignored when full.
//   Enqueue and dequeue in same cycle: count unchanged.
// - accessType from funct3[1:0]: 00->01, 01->10, 10->11.
// - FSM IDLE: head valid and issuable -> drive request exactly 1 cycle
//   (accessType!=00, addr, data, readWriteOut); next state WAIT_LOAD or
//   WAIT_STORE. All other cycles accessType=00.
//   Issuable: store needs committedCount>0; IO load needs robHeadIndex==entry
//   tag; other loads always.
// - WAIT_LOAD: on dataInValid, register resultValid=1 next cycle, extend
//   (LB/LH sign, LBU/LHU zero, LW pass), dequeue, go IDLE. Load-to-result
//   latency >= 2 cycles after issue.
// - WAIT_STORE: on dataWriteSuc, dequeue, committedCount-1, go IDLE. No result.
// - Next issue earliest the cycle after the return to IDLE.
// - commitStoreIn: committedCount+1; same-cycle store completion nets to 0.
// - clearIn: tail<=head+committedCount, count<=committedCount. WAIT_LOAD ->
//   IDLE, response dropped (Cache also cleared). WAIT_STORE continues to
//   completion. Same-cycle enqueue is dropped. Same-cycle commit is counted
//   before truncation. resultValid forced 0 the cycle after clear.
// - Committed stores are always a contiguous prefix from head; never flushed.
// - resetIn mid-transaction: queue discarded, state IDLE, no result pulse.
// CONFIGURATION
// - LSB_STATS_EN defined: extra outputs loadCount[31:0] and storeCount[31:0].
//   Each increments once per completed load/store, wraps at 2^32, and resets
//   to 0. Flushed loads are not counted.
// - LSB_STATS_EN undefined: ports and counters absent; behaviour otherwise
//   identical.
// TESTING
// - LW 0x1000 tag 3; Cache returns 0x12345678 after 20 cycles -> one
//   accessType=11 pulse, readWriteOut=1; resultValid with 0x12345678, tag 3.
// - LB, then LBU, to 0x2001; data 0x80 -> results 0xFFFFFF80, then 0x00000080.
// - SH 0x3002 data 0xBEEF: no request until commitStoreIn; then accessType=10,
//   readWriteOut=0, dataOut[15:0]=0xBEEF; dequeue on dataWriteSuc.
// - Enqueue 16 entries -> full=1; 17th ignored; count stays 16; after one
//   completion full=0 and tail wraps to 0.
// - Queue: committed SW, uncommitted LW, uncommitted SB; clearIn during
//   WAIT_STORE -> SW completes; other 2 dropped; count=0 after dataWriteSuc.
// - LW to 0x30000 tag 5 with robHeadIndex=2 -> no issue; robHeadIndex=5 ->
//   issued the next cycle.

Source files
------------

// File: rtl/load_store_buffer.sv
// In-order load/store queue in front of the cache data port: one request in flight at a time.
// Optional `LSB_STATS_EN adds completed load/store counters (loadCount/storeCount).
module load_store_buffer #(
  parameter int LSB_WIDTH = 4,
  parameter int LSB_SIZE  = 2 ** LSB_WIDTH,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clkIn,
  input  logic                 resetIn,
  input  logic                 clearIn,
  input  logic                 entryInValid,
  input  logic                 entryIsLoad,
  input  logic [2:0]           entryFunct3,
  input  logic [31:0]          entryAddr,
  input  logic [31:0]          entryData,
  input  logic [ROB_WIDTH-1:0] entryRobIndex,
  input  logic                 commitStoreIn,
  input  logic [ROB_WIDTH-1:0] robHeadIndex,
  output logic                 full,
  output logic [1:0]           accessType,
  output logic                 readWriteOut,
  output logic [31:0]          dataAddrOut,
  output logic [31:0]          dataOut,
  input  logic                 dataInValid,
  input  logic [31:0]          dataIn,
  input  logic                 dataWriteSuc,
  output logic                 resultValid,
  output logic [31:0]          resultData,
  output logic [ROB_WIDTH-1:0] resultRobIndex
`ifdef LSB_STATS_EN
  ,
  output logic [31:0]          loadCount,
  output logic [31:0]          storeCount
`endif
);

  typedef logic [LSB_WIDTH-1:0] ptr_t;
  typedef logic [LSB_WIDTH:0]   cnt_t;
  typedef enum logic [1:0] {StIdle, StWaitLoad, StWaitStore} state_e;

  logic                 mem_is_load_q [LSB_SIZE];
  logic [2:0]           mem_funct3_q  [LSB_SIZE];
  logic [31:0]          mem_addr_q    [LSB_SIZE];
  logic [31:0]          mem_data_q    [LSB_SIZE];
  logic [ROB_WIDTH-1:0] mem_rob_q     [LSB_SIZE];

  ptr_t   head_q, head_d, tail_q, tail_d;
  cnt_t   count_q, count_d, committed_q, committed_d;
  state_e state_q;

  logic [1:0]           access_type_q;
  logic                 read_write_q;
  logic [31:0]          addr_q, wdata_q;
  logic                 result_valid_q;
  logic [31:0]          result_data_q;
  logic [ROB_WIDTH-1:0] result_rob_q;

  logic                 head_is_load, head_is_io, issuable, issue;
  logic                 load_done, store_done, deq, enq;
  logic [2:0]           head_f3;
  logic [31:0]          head_addr, head_data, ext_data;
  logic [ROB_WIDTH-1:0] head_rob;
  logic [1:0]           head_access;

  assign full           = (count_q == cnt_t'(LSB_SIZE));
  assign accessType     = access_type_q;
  assign readWriteOut   = read_write_q;
  assign dataAddrOut    = addr_q;
  assign dataOut        = wdata_q;
  assign resultValid    = result_valid_q;
  assign resultData     = result_data_q;
  assign resultRobIndex = result_rob_q;

  always_comb begin
    head_is_load = mem_is_load_q[head_q];
    head_f3      = mem_funct3_q[head_q];
    head_addr    = mem_addr_q[head_q];
    head_data    = mem_data_q[head_q];
    head_rob     = mem_rob_q[head_q];
    head_is_io   = (head_addr[17:16] == 2'b11);

    // A store at the head is necessarily the oldest committed one when committed_q != 0.
    issuable = (count_q != '0) &&
               (head_is_load ? (!head_is_io || (robHeadIndex == head_rob)) : (committed_q != '0));
    issue      = (state_q == StIdle) && issuable && !(clearIn && head_is_load);
    load_done  = (state_q == StWaitLoad) && dataInValid && !clearIn;
    store_done = (state_q == StWaitStore) && dataWriteSuc;
    deq        = load_done || store_done;
    enq        = entryInValid && !full && !clearIn;

    unique case (head_f3[1:0])
      2'b00:   head_access = 2'b01;
      2'b01:   head_access = 2'b10;
      default: head_access = 2'b11;
    endcase

    case (head_f3)
      3'b000:  ext_data = {{24{dataIn[7]}}, dataIn[7:0]};
      3'b001:  ext_data = {{16{dataIn[15]}}, dataIn[15:0]};
      3'b100:  ext_data = {24'b0, dataIn[7:0]};
      3'b101:  ext_data = {16'b0, dataIn[15:0]};
      default: ext_data = dataIn;
    endcase

    committed_d = committed_q;
    if (commitStoreIn) committed_d = committed_d + cnt_t'(1);
    if (store_done)    committed_d = committed_d - cnt_t'(1);

    head_d = deq ? head_q + ptr_t'(1) : head_q;

    if (clearIn) begin
      // Flush keeps only the committed-store prefix starting at the (possibly advanced) head.
      count_d = committed_d;
      tail_d  = head_d + ptr_t'(committed_d);
    end else begin
      count_d = count_q;
      tail_d  = tail_q;
      if (enq) begin
        count_d = count_d + cnt_t'(1);
        tail_d  = tail_q + ptr_t'(1);
      end
      if (deq) count_d = count_d - cnt_t'(1);
    end
  end

  always_ff @(posedge clkIn) begin
    if (enq) begin
      mem_is_load_q[tail_q] <= entryIsLoad;
      mem_funct3_q[tail_q]  <= entryFunct3;
      mem_addr_q[tail_q]    <= entryAddr;
      mem_data_q[tail_q]    <= entryData;
      mem_rob_q[tail_q]     <= entryRobIndex;
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      committed_q    <= '0;
      state_q        <= StIdle;
      access_type_q  <= 2'b00;
      read_write_q   <= 1'b1;
      addr_q         <= '0;
      wdata_q        <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      result_rob_q   <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      committed_q    <= committed_d;
      access_type_q  <= 2'b00;
      result_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            access_type_q <= head_access;
            read_write_q  <= head_is_load;
            addr_q        <= head_addr;
            wdata_q       <= head_data;
            state_q       <= head_is_load ? StWaitLoad : StWaitStore;
          end
        end
        StWaitLoad: begin
          if (load_done) begin
            result_valid_q <= 1'b1;
            result_data_q  <= ext_data;
            result_rob_q   <= head_rob;
          end
          if (clearIn || dataInValid) state_q <= StIdle;
        end
        StWaitStore: begin
          if (dataWriteSuc) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef LSB_STATS_EN
  logic [31:0] load_count_q, store_count_q;

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      load_count_q  <= '0;
      store_count_q <= '0;
    end else begin
      if (load_done)  load_count_q  <= load_count_q + 32'd1;
      if (store_done) store_count_q <= store_count_q + 32'd1;
    end
  end

  assign loadCount  = load_count_q;
  assign storeCount = store_count_q;
`endif

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: loads/extension, committed stores, full, flush, IO loads.
module tb_load_store_buffer;

  logic        clkIn = 1'b0;
  logic        resetIn, clearIn, entryInValid, entryIsLoad, commitStoreIn;
  logic [2:0]  entryFunct3;
  logic [31:0] entryAddr, entryData;
  logic [3:0]  entryRobIndex, robHeadIndex;
  logic        full, readWriteOut, dataInValid, dataWriteSuc, resultValid;
  logic [1:0]  accessType;
  logic [31:0] dataAddrOut, dataOut, dataIn, resultData;
  logic [3:0]  resultRobIndex;

  int checks   = 0;
  int failures = 0;

  load_store_buffer dut (
    .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn),
    .entryInValid(entryInValid), .entryIsLoad(entryIsLoad), .entryFunct3(entryFunct3),
    .entryAddr(entryAddr), .entryData(entryData), .entryRobIndex(entryRobIndex),
    .commitStoreIn(commitStoreIn), .robHeadIndex(robHeadIndex), .full(full),
    .accessType(accessType), .readWriteOut(readWriteOut), .dataAddrOut(dataAddrOut),
    .dataOut(dataOut), .dataInValid(dataInValid), .dataIn(dataIn),
    .dataWriteSuc(dataWriteSuc), .resultValid(resultValid), .resultData(resultData),
    .resultRobIndex(resultRobIndex)
  );

  always #5 clkIn = ~clkIn;

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetIn = 1'b1;
    tick();
    tick();
    resetIn = 1'b0;
  endtask

  task automatic enqueue(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] rob);
    entryInValid = 1'b1; entryIsLoad = ld; entryFunct3 = f3;
    entryAddr = addr; entryData = data; entryRobIndex = rob;
    tick();
    entryInValid = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (accessType == 2'b00 && n < 50) begin
      tick();
      n++;
    end
    check(tag, {31'b0, accessType != 2'b00}, 32'd1);
  endtask

  task automatic idle_pulses(input int n, input string tag);
    int p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (accessType != 2'b00) p++;
    end
    check(tag, p, 0);
  endtask

  task automatic serve_load(input string tag, input logic [31:0] din, input logic [31:0] exp,
                            input logic [3:0] rob);
    dataInValid = 1'b1; dataIn = din;
    tick();
    dataInValid = 1'b0;
    check({tag, "_valid"}, {31'b0, resultValid}, 32'd1);
    check({tag, "_data"}, resultData, exp);
    check({tag, "_rob"}, {28'b0, resultRobIndex}, {28'b0, rob});
  endtask

  initial begin
    resetIn = 1'b0; clearIn = 1'b0; entryInValid = 1'b0; entryIsLoad = 1'b0;
    entryFunct3 = '0; entryAddr = '0; entryData = '0; entryRobIndex = '0;
    commitStoreIn = 1'b0; robHeadIndex = '0; dataInValid = 1'b0; dataIn = '0;
    dataWriteSuc = 1'b0;
    do_reset();

    check("rst_access", {30'b0, accessType}, 32'd0);
    check("rst_rw", {31'b0, readWriteOut}, 32'd1);
    check("rst_addr", dataAddrOut, 32'd0);
    check("rst_dout", dataOut, 32'd0);
    check("rst_rvalid", {31'b0, resultValid}, 32'd0);
    check("rst_rdata", resultData, 32'd0);
    check("rst_rrob", {28'b0, resultRobIndex}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);

    // LW with a 20-cycle cache latency
    enqueue(1'b1, 3'b010, 32'h1000, 32'h0, 4'd3);
    wait_issue("lw_issue");
    check("lw_access", {30'b0, accessType}, 32'd3);
    check("lw_rw", {31'b0, readWriteOut}, 32'd1);
    check("lw_addr", dataAddrOut, 32'h1000);
    idle_pulses(20, "lw_single_pulse");
    serve_load("lw", 32'h1234_5678, 32'h1234_5678, 4'd3);
    tick();
    check("lw_pulse_end", {31'b0, resultValid}, 32'd0);

    // LB then LBU to the same byte
    enqueue(1'b1, 3'b000, 32'h2001, 32'h0, 4'd1);
    enqueue(1'b1, 3'b100, 32'h2001, 32'h0, 4'd2);
    wait_issue("lb_issue");
    check("lb_access", {30'b0, accessType}, 32'd1);
    serve_load("lb", 32'h80, 32'hFFFF_FF80, 4'd1);
    wait_issue("lbu_issue");
    serve_load("lbu", 32'h80, 32'h0000_0080, 4'd2);

    // SH waits for commit
    enqueue(1'b0, 3'b001, 32'h3002, 32'hBEEF, 4'd4);
    idle_pulses(6, "sh_wait_commit");
    commitStoreIn = 1'b1;
    tick();
    commitStoreIn = 1'b0;
    wait_issue("sh_issue");
    check("sh_access", {30'b0, accessType}, 32'd2);
    check("sh_rw", {31'b0, readWriteOut}, 32'd0);
    check("sh_data", {16'b0, dataOut[15:0]}, 32'hBEEF);
    check("sh_addr", dataAddrOut, 32'h3002);
    dataWriteSuc = 1'b1;
    tick();
    dataWriteSuc = 1'b0;
    check("sh_count", {27'b0, dut.count_q}, 32'd0);
    check("sh_no_result", {31'b0, resultValid}, 32'd0);

    // Fill with IO loads that cannot issue yet
    do_reset();
    for (int i = 0; i < 16; i++) enqueue(1'b1, 3'b010, 32'h30000, 32'h0, 4'd7);
    check("fill_full", {31'b0, full}, 32'd1);
    check("fill_tail", {28'b0, dut.tail_q}, 32'd0);
    enqueue(1'b1, 3'b010, 32'h30000, 32'h0, 4'd7);
    check("fill_17_count", {27'b0, dut.count_q}, 32'd16);
    check("fill_17_full", {31'b0, full}, 32'd1);
    robHeadIndex = 4'd7;
    wait_issue("fill_issue");
    serve_load("fill_ld", 32'h55, 32'h55, 4'd7);
    check("fill_notfull", {31'b0, full}, 32'd0);
    check("fill_count", {27'b0, dut.count_q}, 32'd15);
    check("fill_tail_wrap", {28'b0, dut.tail_q}, 32'd0);
    tick();
    // Reset with a load in flight and its data arriving
    resetIn = 1'b1; dataInValid = 1'b1; dataIn = 32'h99;
    tick();
    resetIn = 1'b0; dataInValid = 1'b0; robHeadIndex = 4'd0;
    check("rstmid_rvalid", {31'b0, resultValid}, 32'd0);
    check("rstmid_count", {27'b0, dut.count_q}, 32'd0);
    idle_pulses(3, "rstmid_idle");

    // Flush during a committed store
    enqueue(1'b0, 3'b010, 32'h4000, 32'hCAFE_F00D, 4'd1);
    enqueue(1'b1, 3'b010, 32'h5000, 32'h0, 4'd2);
    enqueue(1'b0, 3'b000, 32'h6000, 32'h11, 4'd3);
    idle_pulses(3, "flush_wait_commit");
    commitStoreIn = 1'b1;
    tick();
    commitStoreIn = 1'b0;
    wait_issue("flush_sw_issue");
    check("flush_sw_rw", {31'b0, readWriteOut}, 32'd0);
    check("flush_sw_data", dataOut, 32'hCAFE_F00D);
    clearIn = 1'b1;
    tick();
    clearIn = 1'b0;
    check("flush_count", {27'b0, dut.count_q}, 32'd1);
    idle_pulses(2, "flush_store_wait");
    dataWriteSuc = 1'b1;
    tick();
    dataWriteSuc = 1'b0;
    check("flush_count_done", {27'b0, dut.count_q}, 32'd0);
    idle_pulses(4, "flush_dropped");

    // Flush while a load waits: response dropped
    enqueue(1'b1, 3'b010, 32'h7000, 32'h0, 4'd6);
    wait_issue("clrld_issue");
    clearIn = 1'b1; dataInValid = 1'b1; dataIn = 32'h77;
    tick();
    clearIn = 1'b0; dataInValid = 1'b0;
    check("clrld_rvalid", {31'b0, resultValid}, 32'd0);
    check("clrld_count", {27'b0, dut.count_q}, 32'd0);

    // IO load waits for ROB head
    robHeadIndex = 4'd2;
    enqueue(1'b1, 3'b010, 32'h30000, 32'h0, 4'd5);
    idle_pulses(5, "io_blocked");
    robHeadIndex = 4'd5;
    tick();
    check("io_access", {30'b0, accessType}, 32'd3);
    check("io_addr", dataAddrOut, 32'h30000);
    serve_load("io", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
